state_mem_arbiter: RTL and testbench

Owns the single port of the neuron state memory and shares it between two requesters: the core controller (time-multiplexed neuron update) and a host port (preload and readback).
Runs an initialisation sweep that writes a fixed state vector to every neuron address, automatically after reset and again on request.
Arbitration is fixed-priority to the core, with a starvation guard for the host.
Sits between main_ctrl/host logic and neuron_state_memory.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/state_mem_arbiter_if.sv | 56 +++++
 rtl/state_mem_init_sweeper.sv | 30 +++
 rtl/state_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_state_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared SNN definitions: state vector geometry, memory depth and arbiter
// state/requester encodings used by the state memory arbiter slice.
package snn_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int FSM_WIDTH       = 2;
  localparam int STATE_VEC_WIDTH = 2 * DATA_WIDTH + FSM_WIDTH;
  localparam int ADDR_WIDTH      = 14;
  localparam int NEURON_COUNT    = 10000;
  localparam int HOST_MAX_WAIT   = 8;

  typedef enum logic {
    ARB_S_INIT,
    ARB_S_ARB
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // Addresses at or past the neuron count are accepted but never touch memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned count);
    return addr < count;
  endfunction

endpackage

// File: rtl/state_mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the state memory
// arbiter; the arbiter uses the slave view, its environment the master view.
interface state_mem_arbiter_if import snn_pkg::*; #(
  parameter int ADDR_WIDTH      = snn_pkg::ADDR_WIDTH,
  parameter int STATE_VEC_WIDTH = snn_pkg::STATE_VEC_WIDTH
);

  logic                       i_init_start;

  logic                       i_core_req;
  logic                       i_core_we;
  logic [ADDR_WIDTH-1:0]      i_core_addr;
  logic [STATE_VEC_WIDTH-1:0] i_core_wdata;
  logic                       o_core_gnt;
  logic                       o_core_rvalid;
  logic [STATE_VEC_WIDTH-1:0] o_core_rdata;

  logic                       i_host_req;
  logic                       i_host_we;
  logic [ADDR_WIDTH-1:0]      i_host_addr;
  logic [STATE_VEC_WIDTH-1:0] i_host_wdata;
  logic                       o_host_gnt;
  logic                       o_host_rvalid;
  logic [STATE_VEC_WIDTH-1:0] o_host_rdata;

  logic [ADDR_WIDTH-1:0]      o_mem_addr;
  logic                       o_mem_wr_en;
  logic [STATE_VEC_WIDTH-1:0] o_mem_wdata;
  logic [STATE_VEC_WIDTH-1:0] i_mem_rdata;

  logic                       o_init_busy;
  logic                       o_ready;

  modport slave (
    input  i_init_start,
    input  i_core_req, i_core_we, i_core_addr, i_core_wdata,
    output o_core_gnt, o_core_rvalid, o_core_rdata,
    input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
    output o_host_gnt, o_host_rvalid, o_host_rdata,
    output o_mem_addr, o_mem_wr_en, o_mem_wdata,
    input  i_mem_rdata,
    output o_init_busy, o_ready
  );

  modport master (
    output i_init_start,
    output i_core_req, i_core_we, i_core_addr, i_core_wdata,
    input  o_core_gnt, o_core_rvalid, o_core_rdata,
    output i_host_req, i_host_we, i_host_addr, i_host_wdata,
    input  o_host_gnt, o_host_rvalid, o_host_rdata,
    input  o_mem_addr, o_mem_wr_en, o_mem_wdata,
    output i_mem_rdata,
    input  o_init_busy, o_ready
  );

endinterface

// File: rtl/state_mem_init_sweeper.sv
// Address counter for the initialisation sweep: walks 0..NEURON_COUNT-1 while
// active, flags the last address and can be pulled back to 0 on restart.
module state_mem_init_sweeper import snn_pkg::*; #(
  parameter int NEURON_COUNT = snn_pkg::NEURON_COUNT,
  parameter int ADDR_WIDTH   = snn_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  active,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NEURON_COUNT - 1);

  assign done = active && (addr == LAST_ADDR);

  // Wrap to 0 after the last write so a later restart always begins clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (restart) begin
      addr <= '0;
    end else if (active) begin
      addr <= done ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/state_mem_arbiter.sv
// Single-port neuron state memory arbiter: init sweep after reset or on
// request, then core-priority arbitration with a host starvation guard.
module state_mem_arbiter import snn_pkg::*; #(
  parameter int                         NEURON_COUNT    = snn_pkg::NEURON_COUNT,
  parameter int                         ADDR_WIDTH      = snn_pkg::ADDR_WIDTH,
  parameter int                         STATE_VEC_WIDTH = snn_pkg::STATE_VEC_WIDTH,
  parameter int                         HOST_MAX_WAIT   = snn_pkg::HOST_MAX_WAIT,
  parameter logic [STATE_VEC_WIDTH-1:0] INIT_VALUE      = '0
) (
  input logic               clk,
  input logic               rst_n,
  state_mem_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

  arb_state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]      init_addr;
  logic                       init_done;
  logic                       sweep_restart;
  logic [WAIT_W-1:0]          host_wait;
  logic                       host_force;
  logic                       core_gnt, host_gnt;
  logic                       win_id;
  logic                       core_in_range, host_in_range;
  logic [ADDR_WIDTH-1:0]      last_addr;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic                       mem_wr_en;
  logic [STATE_VEC_WIDTH-1:0] mem_wdata;
  logic                       core_rd_pend, core_rd_oor;
  logic                       host_rd_pend, host_rd_oor;
  logic [STATE_VEC_WIDTH-1:0] core_rdata_hold, host_rdata_hold;
  logic [STATE_VEC_WIDTH-1:0] core_rdata_now, host_rdata_now;

  state_mem_init_sweeper #(
    .NEURON_COUNT (NEURON_COUNT),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_sweeper (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state == ARB_S_INIT),
    .restart (sweep_restart),
    .addr    (init_addr),
    .done    (init_done)
  );

  assign core_in_range = addr_in_range(32'(bus.i_core_addr), NEURON_COUNT);
  assign host_in_range = addr_in_range(32'(bus.i_host_addr), NEURON_COUNT);
  assign host_force    = (host_wait == WAIT_W'(HOST_MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_S_INIT;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      last_addr <= mem_addr;
    end
  end

  always_comb begin
    state_nxt     = state;
    core_gnt      = 1'b0;
    host_gnt      = 1'b0;
    sweep_restart = 1'b0;
    win_id        = REQ_CORE;
    mem_addr      = last_addr;
    mem_wr_en     = 1'b0;
    mem_wdata     = '0;
    unique case (state)
      ARB_S_INIT: begin
        mem_addr  = init_addr;
        mem_wr_en = 1'b1;
        mem_wdata = INIT_VALUE;
        if (init_done) state_nxt = ARB_S_ARB;
      end
      ARB_S_ARB: begin
        if (bus.i_host_req && (host_force || !bus.i_core_req)) begin
          host_gnt = 1'b1;
        end else if (bus.i_core_req) begin
          core_gnt = 1'b1;
        end
        if (host_gnt) win_id = REQ_HOST;
        if (core_gnt || host_gnt) begin
          if (win_id == REQ_HOST) begin
            mem_addr  = bus.i_host_addr;
            mem_wr_en = bus.i_host_we && host_in_range;
            mem_wdata = bus.i_host_wdata;
          end else begin
            mem_addr  = bus.i_core_addr;
            mem_wr_en = bus.i_core_we && core_in_range;
            mem_wdata = bus.i_core_wdata;
          end
        end
        // A grant in this cycle still completes; only the state moves on.
        if (bus.i_init_start) begin
          sweep_restart = 1'b1;
          state_nxt     = ARB_S_INIT;
        end
      end
      default: state_nxt = ARB_S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_wait <= '0;
    end else if (!bus.i_host_req || host_gnt) begin
      host_wait <= '0;
    end else if (!host_force) begin
      host_wait <= host_wait + 1'b1;
    end
  end

  // Memory data is registered, so read data is forwarded straight through in
  // the return cycle and captured for holding afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rd_pend    <= 1'b0;
      core_rd_oor     <= 1'b0;
      host_rd_pend    <= 1'b0;
      host_rd_oor     <= 1'b0;
      core_rdata_hold <= '0;
      host_rdata_hold <= '0;
    end else begin
      core_rd_pend <= core_gnt && !bus.i_core_we;
      core_rd_oor  <= !core_in_range;
      host_rd_pend <= host_gnt && !bus.i_host_we;
      host_rd_oor  <= !host_in_range;
      if (core_rd_pend) core_rdata_hold <= core_rdata_now;
      if (host_rd_pend) host_rdata_hold <= host_rdata_now;
    end
  end

  assign core_rdata_now = core_rd_oor ? '0 : bus.i_mem_rdata;
  assign host_rdata_now = host_rd_oor ? '0 : bus.i_mem_rdata;

  assign bus.o_core_gnt    = core_gnt;
  assign bus.o_host_gnt    = host_gnt;
  assign bus.o_core_rvalid = core_rd_pend;
  assign bus.o_host_rvalid = host_rd_pend;
  assign bus.o_core_rdata  = core_rd_pend ? core_rdata_now : core_rdata_hold;
  assign bus.o_host_rdata  = host_rd_pend ? host_rdata_now : host_rdata_hold;

  // Keep the memory quiet while reset is held, even though INIT drives a write.
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wr_en = mem_wr_en && rst_n;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_init_busy = (state == ARB_S_INIT);
  assign bus.o_ready     = (state == ARB_S_ARB);

endmodule

// File: tb/tb_state_mem_arbiter.sv
// Scoreboard bench for state_mem_arbiter with a 16-entry write-first memory
// model; read responses are queued at grant time and checked by a monitor.
module tb_state_mem_arbiter;
  import snn_pkg::*;

  localparam int NC  = 16;
  localparam int AW  = 14;
  localparam int SW  = 18;
  localparam int HMW = 8;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic [SW-1:0] coreQ[$];
  logic [SW-1:0] hostQ[$];
  logic [SW-1:0] mem [0:NC-1];

  state_mem_arbiter_if #(.ADDR_WIDTH(AW), .STATE_VEC_WIDTH(SW)) bus();

  state_mem_arbiter #(
    .NEURON_COUNT    (NC),
    .ADDR_WIDTH      (AW),
    .STATE_VEC_WIDTH (SW),
    .HOST_MAX_WAIT   (HMW),
    .INIT_VALUE      ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first registered memory, as the arbiter expects.
  always @(posedge clk) begin
    if (bus.o_mem_wr_en) begin
      mem[bus.o_mem_addr[3:0]] <= bus.o_mem_wdata;
      bus.i_mem_rdata          <= bus.o_mem_wdata;
    end else begin
      bus.i_mem_rdata <= mem[bus.o_mem_addr[3:0]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_core_rvalid) begin
      if (coreQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL core_unexpected_rvalid: got rdata 0x%0h, expected no rvalid", bus.o_core_rdata);
      end else begin
        checkOutput("core_rdata", 32'(bus.o_core_rdata), 32'(coreQ.pop_front()));
      end
    end
    if (bus.o_host_rvalid) begin
      if (hostQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL host_unexpected_rvalid: got rdata 0x%0h, expected no rvalid", bus.o_host_rdata);
      end else begin
        checkOutput("host_rdata", 32'(bus.o_host_rdata), 32'(hostQ.pop_front()));
      end
    end
  end

  task automatic idleInputs();
    bus.i_init_start = 1'b0;
    bus.i_core_req   = 1'b0;
    bus.i_core_we    = 1'b0;
    bus.i_core_addr  = '0;
    bus.i_core_wdata = '0;
    bus.i_host_req   = 1'b0;
    bus.i_host_we    = 1'b0;
    bus.i_host_addr  = '0;
    bus.i_host_wdata = '0;
  endtask

  task automatic holdCoreRead(input logic [AW-1:0] addr);
    idleInputs();
    bus.i_core_req  = 1'b1;
    bus.i_core_addr = addr;
  endtask

  // One arbitration cycle; a read expected to win queues its hand-computed data.
  task automatic applyStimulus(
    input logic cReq, input logic cWe, input logic [AW-1:0] cAddr, input logic [SW-1:0] cData,
    input logic hReq, input logic hWe, input logic [AW-1:0] hAddr, input logic [SW-1:0] hData,
    input logic expCore, input logic expHost, input logic [SW-1:0] expRdata,
    input logic initStart
  );
    @(posedge clk);
    #1;
    bus.i_init_start = initStart;
    bus.i_core_req   = cReq;
    bus.i_core_we    = cWe;
    bus.i_core_addr  = cAddr;
    bus.i_core_wdata = cData;
    bus.i_host_req   = hReq;
    bus.i_host_we    = hWe;
    bus.i_host_addr  = hAddr;
    bus.i_host_wdata = hData;
    @(negedge clk);
    checkOutput("core_gnt", 32'(bus.o_core_gnt), 32'(expCore));
    checkOutput("host_gnt", 32'(bus.o_host_gnt), 32'(expHost));
    if (expCore && !cWe) coreQ.push_back(expRdata);
    if (expHost && !hWe) hostQ.push_back(expRdata);
  endtask

  task automatic checkReset();
    @(negedge clk);
    checkOutput("rst_wr_en",     32'(bus.o_mem_wr_en),   32'd0);
    checkOutput("rst_init_busy", 32'(bus.o_init_busy),   32'd1);
    checkOutput("rst_ready",     32'(bus.o_ready),       32'd0);
    checkOutput("rst_core_gnt",  32'(bus.o_core_gnt),    32'd0);
    checkOutput("rst_host_gnt",  32'(bus.o_host_gnt),    32'd0);
    checkOutput("rst_core_rv",   32'(bus.o_core_rvalid), 32'd0);
    checkOutput("rst_host_rv",   32'(bus.o_host_rvalid), 32'd0);
    checkOutput("rst_core_rd",   32'(bus.o_core_rdata),  32'd0);
    checkOutput("rst_host_rd",   32'(bus.o_host_rdata),  32'd0);
  endtask

  // Entered just after a posedge with a core read of addr 2 held; stopAt < NC
  // returns right after that sweep address is observed.
  task automatic checkSweep(input int stopAt);
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      checkOutput("sweep_addr",  32'(bus.o_mem_addr),  32'(i));
      checkOutput("sweep_wr_en", 32'(bus.o_mem_wr_en), 32'd1);
      checkOutput("sweep_wdata", 32'(bus.o_mem_wdata), 32'd0);
      checkOutput("sweep_busy",  32'(bus.o_init_busy), 32'd1);
      checkOutput("sweep_ready", 32'(bus.o_ready),     32'd0);
      checkOutput("sweep_nognt", 32'(bus.o_core_gnt),  32'd0);
      if (i == stopAt) return;
    end
    @(negedge clk);
    checkOutput("post_sweep_ready", 32'(bus.o_ready),     32'd1);
    checkOutput("post_sweep_busy",  32'(bus.o_init_busy), 32'd0);
    checkOutput("post_sweep_gnt",   32'(bus.o_core_gnt),  32'd1);
    coreQ.push_back(18'h0);
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    holdCoreRead(14'd2);
    checkSweep(NC);

    // Host preload then core readback, and hold of rdata afterwards.
    applyStimulus(1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b1, 14'd5, 18'h2A5F, 1'b0, 1'b1, 18'h0, 1'b0);
    checkOutput("host_wr_en", 32'(bus.o_mem_wr_en), 32'd1);
    checkOutput("host_waddr", 32'(bus.o_mem_addr),  32'd5);
    checkOutput("host_wdata", 32'(bus.o_mem_wdata), 32'h2A5F);
    applyStimulus(1'b1, 1'b0, 14'd5, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h2A5F, 1'b0);
    checkOutput("core_rd_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 14'd0, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b0);
    checkOutput("idle_wr_en",   32'(bus.o_mem_wr_en), 32'd0);
    checkOutput("idle_addr_hold", 32'(bus.o_mem_addr), 32'd5);
    applyStimulus(1'b0, 1'b0, 14'd0, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b0, 1'b0, 18'h0, 1'b0);
    checkOutput("core_rdata_hold", 32'(bus.o_core_rdata), 32'h2A5F);

    // Starvation guard: host forced through on its ninth request cycle.
    for (int i = 1; i <= 9; i++)
      applyStimulus(1'b1, 1'b0, 14'd1, 18'h0, 1'b1, 1'b0, 14'd5, 18'h0,
                    (i < 9), (i == 9), (i == 9) ? 18'h2A5F : 18'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 14'd1, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h0, 1'b0);

    // Wait reaches 4 under core priority, host-only grant clears it.
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 1'b0, 14'd1, 18'h0, 1'b1, 1'b1, 14'd7, 18'h777, 1'b1, 1'b0, 18'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b1, 14'd7, 18'h777, 1'b0, 1'b1, 18'h0, 1'b0);
    for (int i = 1; i <= 9; i++)
      applyStimulus(1'b1, 1'b0, 14'd1, 18'h0, 1'b1, 1'b1, 14'd7, 18'h777, (i < 9), (i == 9), 18'h0, 1'b0);

    // Out-of-range accesses, then confirm nothing aliased onto addr 0.
    applyStimulus(1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b1, 14'd16, 18'h3FFFF, 1'b0, 1'b1, 18'h0, 1'b0);
    checkOutput("oor_wr_en", 32'(bus.o_mem_wr_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 14'd20, 18'h0, 1'b0, 1'b1, 18'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 14'd0, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h0, 1'b0);

    // Back-to-back write then read of the same address.
    applyStimulus(1'b1, 1'b1, 14'd3, 18'h1234, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h0, 1'b0);
    checkOutput("b2b_wr_en", 32'(bus.o_mem_wr_en), 32'd1);
    applyStimulus(1'b1, 1'b0, 14'd3, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h1234, 1'b0);
    applyStimulus(1'b1, 1'b0, 14'd7, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h777, 1'b0);

    // Re-init requested in the same cycle as a core read grant.
    applyStimulus(1'b1, 1'b0, 14'd5, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h2A5F, 1'b1);
    @(posedge clk);
    #1;
    holdCoreRead(14'd2);
    checkSweep(NC);

    // Reset while a read is outstanding: its response must never appear.
    applyStimulus(1'b1, 1'b0, 14'd3, 18'h0, 1'b0, 1'b0, 14'd0, 18'h0, 1'b1, 1'b0, 18'h0, 1'b0);
    void'(coreQ.pop_back());
    rst_n = 1'b0;
    checkReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    holdCoreRead(14'd2);
    checkSweep(9);
    rst_n = 1'b0;
    checkReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkSweep(NC);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("core_queue_empty", 32'(coreQ.size()), 32'd0);
    checkOutput("host_queue_empty", 32'(hostQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
